// File: rtl/mult_pkg.sv
// Shared defaults, state type and helpers for the
// dot-product stage that sits after the 4x4 multiplier.
package mult_pkg;

  localparam int DP_WIDTH  = 4;
  localparam int DP_PROD_W = 8;
  localparam int DP_LEN    = 4;
  localparam int DP_ACC_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } dp_state_t;

  // Bits needed to index v distinct values.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dot_product_accum.sv
// Registers operand pairs onto an external multiplier and
// accumulates LEN products into a handshaked dot product.
module dot_product_accum
  import mult_pkg::*;
#(
  parameter int WIDTH  = DP_WIDTH,
  parameter int PROD_W = DP_PROD_W,
  parameter int LEN    = DP_LEN,
  parameter int ACC_W  = DP_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_y,
  output logic [WIDTH-1:0]  mul_x,
  output logic [WIDTH-1:0]  mul_y,
  input  logic [PROD_W-1:0] mul_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum
);

  // Counters must be able to hold LEN itself.
  localparam int CNT_W = (clog2(LEN + 1) < 1) ?
                         1 : clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

  dp_state_t        state;
  dp_state_t        state_nxt;
  logic             s1_vld;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] prod_cnt;
  logic             accept;
  logic             last;
  logic             drain;

  assign in_ready = (state != DONE) &&
                    (acc_cnt < LEN_C);
  assign accept   = in_valid && in_ready;
  assign last     = s1_vld && (prod_cnt == LAST_C);
  assign drain    = out_valid && out_ready;
  assign acc_nxt  = acc + ACC_W'(mul_o);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; flush abandons any partial sum.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ACCUM;
      ACCUM:   if (last)   state_nxt = DONE;
      DONE:    if (drain)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Operand stage feeding the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_x  <= '0;
      mul_y  <= '0;
      s1_vld <= 1'b0;
    end else if (flush) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        mul_x <= in_x;
        mul_y <= in_y;
      end
    end
  end

  // Accumulator, counters and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_cnt   <= '0;
      prod_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (flush) begin
      acc       <= '0;
      acc_cnt   <= '0;
      prod_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (drain) begin
      acc       <= '0;
      acc_cnt   <= '0;
      prod_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + 1'b1;
      if (s1_vld) begin
        acc      <= acc_nxt;
        prod_cnt <= prod_cnt + 1'b1;
        if (last) begin
          out_sum   <= acc_nxt;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
